// File: rtl/acc_arb.sv
// acc_arb: shares one accumulator between NREQ requesters with round-robin or locked-burst grants.
// Optional build macro ACC_ARB_FIXED_PRIO_EN switches the search to fixed lowest-index-first priority.
module acc_arb #(
    parameter int WIDTH    = 8,
    parameter int NREQ     = 4,
    parameter int MAX_LOCK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic                  acc_en,
    output logic [WIDTH-1:0]      acc_in,
    input  logic                  acc_z,
    output logic [NREQ-1:0]       z_out,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] LOCK_LIM = 4'(MAX_LOCK - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_LOCK  = 2'd2
    } state_t;

    state_t          r_state, w_state_nx;
    logic [NREQ-1:0] r_gnt, w_gnt_nx;
    logic [IW-1:0]   r_owner, w_owner_nx;
    logic [IW-1:0]   r_last, w_last_nx;
    logic [3:0]      r_cnt, w_cnt_nx;
    logic [IW-1:0]   w_start;
    logic [IW-1:0]   w_win;
    logic [NREQ-1:0] w_onehot;
    logic            w_found;
    logic            w_xfer;
    logic            w_release;
    logic [WIDTH-1:0] w_acc_in;

    // Handshake: a requester holds req until it sees gnt; a write happens in any cycle
    // where gnt and req of the same index are both high, and gnt drops the edge after req drops.

`ifdef ACC_ARB_FIXED_PRIO_EN
    assign w_start = '0;
`else
    logic [IW-1:0] w_base;
    // In IDLE the pointer holds the last owner; while granted the owner becomes last on release.
    assign w_base  = (r_state == S_IDLE) ? r_last : r_owner;
    assign w_start = (int'(w_base) == NREQ - 1) ? '0 : w_base + 1'b1;
`endif

    always_comb begin
        int idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(w_start) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = IW'(idx);
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_onehot[i] = (w_win == IW'(i));
        end
    end

    assign w_xfer = req[r_owner];

    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_owner_nx = r_owner;
        w_last_nx  = r_last;
        w_cnt_nx   = r_cnt;
        w_release  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nx = S_GRANT;
                    w_gnt_nx   = w_onehot;
                    w_owner_nx = w_win;
                end
            end
            S_GRANT: begin
                if (w_xfer && lock[r_owner] && (MAX_LOCK > 1)) begin
                    w_state_nx = S_LOCK;
                    w_cnt_nx   = 4'd1;
                end else begin
                    w_release = 1'b1;
                end
            end
            S_LOCK: begin
                if (!w_xfer || !lock[r_owner] || (r_cnt == LOCK_LIM)) begin
                    w_release = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_gnt_nx   = '0;
            end
        endcase
        // Release hands over back-to-back: the search already starts just past the owner.
        if (w_release) begin
            w_last_nx = r_owner;
            w_cnt_nx  = '0;
            if (w_found) begin
                w_state_nx = S_GRANT;
                w_gnt_nx   = w_onehot;
                w_owner_nx = w_win;
            end else begin
                w_state_nx = S_IDLE;
                w_gnt_nx   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_last  <= IW'(NREQ - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_owner <= w_owner_nx;
            r_last  <= w_last_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_acc_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) w_acc_in = w_acc_in | wdata[i*WIDTH +: WIDTH];
        end
    end

    assign gnt       = r_gnt;
    assign acc_en    = |(r_gnt & req);
    assign acc_in    = w_acc_in;
    assign z_out     = {NREQ{acc_z}};
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_acc_arb.sv
// Directed bench for acc_arb: per-cycle grant/enable checks plus a write-data scoreboard
// feeding a bench-side accumulator whose zero flag loops back into the arbiter.
module tb_acc_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        acc_en;
    logic [7:0]  acc_in;
    logic        acc_z;
    logic [3:0]  z_out;
    logic        busy;
    logic [1:0]  dbg_state;

    logic [7:0]  acc = '0;
    logic [7:0]  exp_acc;
    logic [7:0]  exp_q[$];
    int          n_tests;
    int          n_fail;

    acc_arb #(.WIDTH(8), .NREQ(4), .MAX_LOCK(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .wdata(wdata),
        .gnt(gnt), .acc_en(acc_en), .acc_in(acc_in), .acc_z(acc_z),
        .z_out(z_out), .busy(busy), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external accumulator: not reset by rst_n, so a write after reset assertion would show
    always @(posedge clk) begin
        if (acc_en) acc <= acc_in;
    end
    assign acc_z = (acc == 8'h00);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        wdata = '0;
        exp_q.delete();
        #1;
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_acc_en", {31'd0, acc_en}, 32'd0);
        chk("rst_acc_in", {24'd0, acc_in}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [31:0] wd,
                        input logic [3:0] exp_g, input logic exp_en);
        logic [7:0] exp_in;
        logic [7:0] got;
        exp_in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (exp_g[i]) exp_in = wd[i*8 +: 8];
        end
        req   = r;
        lock  = l;
        wdata = wd;
        if (exp_en) exp_q.push_back(exp_in);
        #1;
        chk("gnt", {28'd0, gnt}, {28'd0, exp_g});
        chk("acc_en", {31'd0, acc_en}, {31'd0, exp_en});
        chk("busy", {31'd0, busy}, {31'd0, |exp_g});
        chk("acc_in", {24'd0, acc_in}, {24'd0, exp_in});
        chk("acc", {24'd0, acc}, {24'd0, exp_acc});
        chk("z_out", {28'd0, z_out}, {28'd0, {4{exp_acc == 8'h00}}});
        if (acc_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_write", {24'd0, acc_in}, 32'hFFFF_FFFF);
            end else begin
                got = exp_q.pop_front();
                chk("sb_write", {24'd0, acc_in}, {24'd0, got});
            end
        end
        exp_q.delete();
        @(posedge clk);
        if (exp_en) exp_acc = exp_in;
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_acc = 8'h00;
        rst_n   = 1'b1;
        req     = '0;
        lock    = '0;
        wdata   = '0;
        #3;

`ifdef ACC_ARB_FIXED_PRIO_EN
        do_reset();
        step(4'b0110, 4'b0000, $urandom, 4'b0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(4'b0110, 4'b0000, $urandom, 4'b0010, 1'b1);
        end
        step(4'b0000, 4'b0000, $urandom, 4'b0010, 1'b0);
        step(4'b0000, 4'b0000, $urandom, 4'b0000, 1'b0);
`else
        // single requester: first grant one edge after req, write lands the edge after
        do_reset();
        step(4'b0001, 4'b0000, 32'h0000_003C, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 32'h0000_003C, 4'b0001, 1'b1);
        step(4'b0000, 4'b0000, 32'h0000_0011, 4'b0001, 1'b0);
        step(4'b0000, 4'b0000, 32'h0000_0011, 4'b0000, 1'b0);

        // all requesting, no lock: strict rotation with no idle cycles
        do_reset();
        step(4'b1111, 4'b0000, $urandom, 4'b0000, 1'b0);
        step(4'b1111, 4'b0000, $urandom, 4'b0001, 1'b1);
        step(4'b1111, 4'b0000, $urandom, 4'b0010, 1'b1);
        step(4'b1111, 4'b0000, $urandom, 4'b0100, 1'b1);
        step(4'b1111, 4'b0000, $urandom, 4'b1000, 1'b1);
        step(4'b1111, 4'b0000, $urandom, 4'b0001, 1'b1);
        step(4'b0000, 4'b0000, $urandom, 4'b0010, 1'b0);
        step(4'b0000, 4'b0000, $urandom, 4'b0000, 1'b0);

        // locked requester 0 against requester 1: 4 writes, 1 handover, repeat
        do_reset();
        step(4'b0011, 4'b0001, $urandom, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0011, 4'b0001, $urandom, 4'b0001, 1'b1);
        step(4'b0011, 4'b0001, $urandom, 4'b0010, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0011, 4'b0001, $urandom, 4'b0001, 1'b1);
        step(4'b0011, 4'b0001, $urandom, 4'b0010, 1'b1);
        step(4'b0000, 4'b0000, $urandom, 4'b0001, 1'b0);
        step(4'b0000, 4'b0000, $urandom, 4'b0000, 1'b0);

        // requester 2 drops req while granted: no write, grant moves to requester 3
        do_reset();
        step(4'b0100, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0);
        step(4'b1000, 4'b0000, 32'h5A66_0000, 4'b0100, 1'b0);
        step(4'b1000, 4'b0000, 32'h7700_0000, 4'b1000, 1'b1);
        step(4'b0000, 4'b0000, 32'h0000_0000, 4'b1000, 1'b0);
        step(4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0);

        // locked burst 01 then 00 drives the zero flag; then reset mid-burst
        do_reset();
        step(4'b0100, 4'b0100, 32'h0001_0000, 4'b0000, 1'b0);
        step(4'b0100, 4'b0100, 32'h0001_0000, 4'b0100, 1'b1);
        step(4'b0100, 4'b0100, 32'h0000_0000, 4'b0100, 1'b1);
        step(4'b0100, 4'b0100, 32'h00AA_0000, 4'b0100, 1'b1);
        rst_n = 1'b0;
        wdata = 32'h0077_0000;
        #1;
        chk("midrst_gnt", {28'd0, gnt}, 32'd0);
        chk("midrst_acc_en", {31'd0, acc_en}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_state", {30'd0, dbg_state}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, 4'b0000, $urandom, 4'b0000, 1'b0);
        step(4'b1111, 4'b0000, $urandom, 4'b0001, 1'b1);
        step(4'b0000, 4'b0000, $urandom, 4'b0010, 1'b0);
        step(4'b0000, 4'b0000, $urandom, 4'b0000, 1'b0);
`endif

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
